// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: BCD nibble width and the
// active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  // Active-low: a 0 bit lights the segment.
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Codes above 9 are not valid BCD and show a dash (segment g only).
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  // Nibble decode; invalid codes fall through to the dash pattern.
  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for packed BCD time digits.
// All digits (and the blink mask) are snapshotted once per frame on the wrap
// from the last digit to digit 0, so a frame never mixes old and new values.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the most significant
// digit when its snapshot value is 0.
module bcd_display_scanner
  import clock_disp_pkg::*;
#(
  parameter int unsigned           NUM_DIGITS   = 6,
  parameter int unsigned           REFRESH_DIV  = 4,
  parameter int unsigned           BLINK_FRAMES = 50,
  parameter logic [NUM_DIGITS-1:0] DP_MASK      = NUM_DIGITS'(6'b010100)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic                        frame_done
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_FRAMES - 1);

  logic [RefW-1:0]             ref_cnt_q, ref_cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [BCD_W*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]       mask_snap_q, mask_snap_d;
  logic [BlkW-1:0]             blink_cnt_q, blink_cnt_d;
  logic                        blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic                        frame_done_q, frame_done_d;

  logic                        advance;
  logic                        wrap;
  int unsigned                 sel;
  logic [BCD_W-1:0]            cur_nib;
  logic [SEG_W-1:0]            cur_seg;
  logic                        blank;

  // Pattern for the digit about to be shown.
  bcd_to_seg7 u_dec (
    .bcd_i (cur_nib),
    .seg_o (cur_seg)
  );

  // Refresh/scan/blink counters and snapshot capture.
  always_comb begin
    ref_cnt_d     = ref_cnt_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    mask_snap_d   = mask_snap_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    advance = (ref_cnt_q == RefLast);
    wrap    = advance && (idx_q == IdxLast);

    if (advance) begin
      ref_cnt_d = '0;
      idx_d     = wrap ? '0 : idx_q + IdxW'(1);
    end else begin
      ref_cnt_d = ref_cnt_q + RefW'(1);
    end

    if (wrap) begin
      snap_d      = digits_in;
      mask_snap_d = blink_mask;
      if (blink_cnt_q == BlkLast) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlkW'(1);
      end
    end

    frame_done_d = wrap;
  end

  // Output pattern for the new index; uses next-state snapshot/phase so digit 0
  // on a wrap shows the value being latched on that same edge.
  always_comb begin
    sel     = 32'(idx_d);
    cur_nib = snap_d[BCD_W*sel +: BCD_W];
    blank   = blink_phase_d && mask_snap_d[sel];
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_d == IdxLast) && (cur_nib == '0)) begin
      blank = 1'b1;
    end
`endif

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (advance) begin
      an_d = '1;
      if (blank) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        an_d[sel] = 1'b0;
        seg_d     = cur_seg;
        dp_d      = ~DP_MASK[sel];
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_cnt_q     <= '0;
      idx_q         <= IdxLast;
      snap_q        <= '0;
      mask_snap_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      mask_snap_q   <= mask_snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: NUM_DIGITS=6, REFRESH_DIV=4,
// BLINK_FRAMES=2, plus a REFRESH_DIV=1 instance checked after reset.
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic [23:0] digits_in;
  logic [5:0]  blink_mask;
  logic [6:0]  seg_out, seg_fast;
  logic        dp_out, dp_fast;
  logic [5:0]  an_out, an_fast;
  logic        frame_done, fd_fast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16];
  localparam logic [5:0] DPM = 6'b010100;

  typedef struct {
    logic [23:0] shown;
    logic [5:0]  dark;
    logic [23:0] next_in;
    logic [5:0]  next_mask;
  } frame_vec_t;

  frame_vec_t frames [8];

  bcd_display_scanner #(
    .NUM_DIGITS   (6),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2),
    .DP_MASK      (6'b010100)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  bcd_display_scanner #(
    .NUM_DIGITS   (6),
    .REFRESH_DIV  (1),
    .BLINK_FRAMES (2),
    .DP_MASK      (6'b010100)
  ) u_fast (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .seg_out    (seg_fast),
    .dp_out     (dp_fast),
    .an_out     (an_fast),
    .frame_done (fd_fast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [5:0] an_e, input logic [6:0] seg_e,
                          input logic dp_e, input logic fd_e);
    chk({tag, ".an"},  32'(an_out),     32'(an_e));
    chk({tag, ".seg"}, 32'(seg_out),    32'(seg_e));
    chk({tag, ".dp"},  32'(dp_out),     32'(dp_e));
    chk({tag, ".fd"},  32'(frame_done), 32'(fd_e));
  endtask

  // Called right after a wrap edge; checks all six slots and ends on the next wrap.
  // Inputs for the following frame are changed while digit 3 is lit.
  task automatic run_frame(input int f, input frame_vec_t v);
    for (int k = 0; k < 6; k++) begin
      logic [3:0] nib;
      logic       blank;
      logic [5:0] an_e;
      string      tag;
      nib   = v.shown[4*k +: 4];
      blank = v.dark[k];
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 5 && nib == 4'h0) blank = 1'b1;
`endif
      an_e = 6'h3F;
      if (!blank) an_e[k] = 1'b0;
      tag = $sformatf("f%0d.d%0d", f, k);
      chk_main(tag, an_e, blank ? 7'h7F : seg_tab[nib], blank ? 1'b1 : ~DPM[k], k == 0);
      if (k == 0) begin
        tick(1);
        chk({tag, ".fd_low"}, 32'(frame_done), 32'd0);
        chk({tag, ".hold_an"}, 32'(an_out), 32'(an_e));
        tick(3);
      end else if (k == 3) begin
        digits_in  = v.next_in;
        blink_mask = v.next_mask;
        tick(4);
      end else begin
        tick(4);
      end
    end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;

    // Blink phase (2 frames per half-period) is high for frames from the 2nd,3rd,6th,7th wraps.
    frames[0] = '{24'h123456, 6'h00, 24'h000009, 6'h00};
    frames[1] = '{24'h000009, 6'h00, 24'h78BFA9, 6'h00};
    frames[2] = '{24'h78BFA9, 6'h00, 24'h123456, 6'h03};
    frames[3] = '{24'h123456, 6'h00, 24'h123456, 6'h03};
    frames[4] = '{24'h123456, 6'h00, 24'h123456, 6'h03};
    frames[5] = '{24'h123456, 6'h03, 24'h123456, 6'h03};
    frames[6] = '{24'h123456, 6'h03, 24'h123456, 6'h03};
    frames[7] = '{24'h123456, 6'h00, 24'h123456, 6'h00};

    rst        = 1'b0;
    digits_in  = 24'h123456;
    blink_mask = 6'h00;

    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_main($sformatf("rst%0d", i), 6'h3F, 7'h7F, 1'b1, 1'b0);
    end

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_main($sformatf("pre%0d", i), 6'h3F, 7'h7F, 1'b1, 1'b0);
    end
    tick(1);

    for (int f = 0; f < 8; f++) run_frame(f, frames[f]);

    // Mid-frame reset with digit 3 lit.
    tick(12);
    chk_main("mid.d3", 6'b110111, seg_tab[3], 1'b1, 1'b0);
    rst = 1'b0;
    tick(1);
    chk_main("midrst", 6'h3F, 7'h7F, 1'b1, 1'b0);
    chk("midrst.fast_an", 32'(an_fast), 32'h3F);
    rst = 1'b1;

    // REFRESH_DIV=1 advances every cycle, first edge after release is a wrap.
    for (int i = 0; i < 4; i++) begin
      logic [5:0] an_e;
      an_e    = 6'h3F;
      an_e[i] = 1'b0;
      tick(1);
      chk($sformatf("fast%0d.an", i), 32'(an_fast), 32'(an_e));
      chk($sformatf("fast%0d.seg", i), 32'(seg_fast), 32'(seg_tab[4'(6 - i)]));
      chk($sformatf("fast%0d.fd", i), 32'(fd_fast), 32'(i == 0));
      if (i < 3) chk($sformatf("rel%0d.an", i), 32'(an_out), 32'h3F);
    end

    run_frame(8, frames[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
